ram_test_sequencer: RTL and testbench

//  Parametrised RAM write/read-back test engine. Sits between control logic and RAMController.
//  Per block: writes a generated pattern, reads it back and compares every word.

---
 rtl/ram_test_sequencer_pkg.sv | 30 +++
 rtl/ram_test_pattern.sv | 49 ++++
 rtl/ram_test_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_ram_test_sequencer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_test_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// ram_test_sequencer_pkg
//   Shared definitions for the RAM write/read-back test engine:
//     - RAMController command encodings (None/Write/Read)
//     - data pattern mode encodings
//     - width of the saturating error counter
//     - `RegWidth(value): number of bits needed to hold 0..value (minimum 1)
//   No ports (package).
//   Optional feature macro used by the engine: RAM_TEST_ERRLOG_EN.
// -----------------------------------------------------------------------------
`ifndef RegWidth
`define RegWidth(value) ((((value)) < 2) ? 1 : $clog2((value) + 1))
`endif

package ram_test_sequencer_pkg;

    localparam logic [1:0] RAMController_Cmd_None  = 2'd0;
    localparam logic [1:0] RAMController_Cmd_Write = 2'd1;
    localparam logic [1:0] RAMController_Cmd_Read  = 2'd2;

    typedef enum logic [1:0] {
        PAT_BLOCK_XOR_IDX = 2'd0,  // block ^ idx
        PAT_IDX           = 2'd1,  // idx
        PAT_BLOCK_XNOR    = 2'd2,  // ~(block ^ idx)
        PAT_WALKING_ONE   = 2'd3   // 1 << (idx mod DataWidth)
    } pattern_mode_e;

    localparam int ErrCountWidth = 16;

endpackage

// File: rtl/ram_test_pattern.sv
// -----------------------------------------------------------------------------
// ram_test_pattern
//   Combinational pattern generator. The same instance feeds write_data and
//   the expected read-back value, so the two can never disagree.
//   Ports:
//     mode_i   in  2           pattern select (pattern_mode_e)
//     block_i  in  BlockWidth  block address of the word
//     idx_i    in  IdxWidth    word index inside the block
//     word_o   out DataWidth   generated pattern word
// -----------------------------------------------------------------------------
module ram_test_pattern
    import ram_test_sequencer_pkg::*;
#(
    parameter int DataWidth  = 16,
    parameter int BlockWidth = 19,
    parameter int IdxWidth   = 4
) (
    input  logic [1:0]            mode_i,
    input  logic [BlockWidth-1:0] block_i,
    input  logic [IdxWidth-1:0]   idx_i,
    output logic [DataWidth-1:0]  word_o
);

    logic [DataWidth-1:0] block_ext;
    logic [DataWidth-1:0] idx_ext;
    logic [DataWidth-1:0] block_xor_idx;
    logic [DataWidth-1:0] walking_one;

    // Block-address bits above DataWidth never reach the pattern word.
    logic unused_block_bits;
    assign unused_block_bits = ^block_i;

    // NOTE: every output of an always_comb gets a value on every path (defaults
    // first / full case with default), otherwise synthesis infers a latch.
    always_comb begin
        block_ext     = DataWidth'(block_i);
        idx_ext       = DataWidth'(idx_i);
        block_xor_idx = block_ext ^ idx_ext;
        walking_one   = DataWidth'(1) << (32'(idx_i) % DataWidth);

        case (pattern_mode_e'(mode_i))
            PAT_BLOCK_XOR_IDX: word_o = block_xor_idx;
            PAT_IDX:           word_o = idx_ext;
            PAT_BLOCK_XNOR:    word_o = ~block_xor_idx;
            default:           word_o = walking_one;
        endcase
    end

endmodule

// File: rtl/ram_test_sequencer.sv
// -----------------------------------------------------------------------------
// ram_test_sequencer
//   RAM write/read-back test engine placed between control logic and the
//   RAMController. For each block of a run it writes a generated pattern,
//   reads it back and compares every word. Errors (miscompares and watchdog
//   expiries) are counted, saturating, instead of halting the run.
//
//   Optional feature: define RAM_TEST_ERRLOG_EN to add err_block/err_idx/
//   err_exp/err_act, which capture the first miscompare of a run.
//
//   Ports:
//     clk            in   1           system clock
//     rst_           in   1           synchronous active-low reset
//     start          in   1           1-cycle pulse, starts a run when idle
//     start_block    in   BlockWidth  first block of the run (sampled on start)
//     mode           in   2           pattern select (sampled on start)
//     busy           out  1           run in progress
//     done           out  1           1-cycle pulse at end of run
//     pass_ok        out  1           valid from done to next start, 1 = no errors
//     err_count      out  16          saturating miscompare + timeout count
//     timeout        out  1           sticky, a watchdog expired during this run
//     cmd            out  2           RAMController command
//     cmd_block      out  BlockWidth  block address for cmd
//     write_ready    in   1           controller accepts write_data
//     write_trigger  out  1           write request
//     write_data     out  DataWidth   pattern word
//     read_ready     in   1           read_data valid
//     read_trigger   out  1           read request
//     read_data      in   DataWidth   word from RAM
//     err_block/err_idx/err_exp/err_act  out  (RAM_TEST_ERRLOG_EN only)
// -----------------------------------------------------------------------------
module ram_test_sequencer
    import ram_test_sequencer_pkg::*;
#(
    parameter int DataWidth     = 16,
    parameter int BlockWidth    = 19,
    parameter int BlockSize     = 16,
    parameter int BlockCount    = 8,
    parameter int TimeoutCycles = 1023,
    parameter int StopOnError   = 0,
    localparam int IdxWidth     = `RegWidth(BlockSize - 1)
) (
    input  logic                     clk,
    input  logic                     rst_,
    input  logic                     start,
    input  logic [BlockWidth-1:0]    start_block,
    input  logic [1:0]               mode,
    output logic                     busy,
    output logic                     done,
    output logic                     pass_ok,
    output logic [ErrCountWidth-1:0] err_count,
    output logic                     timeout,
    output logic [1:0]               cmd,
    output logic [BlockWidth-1:0]    cmd_block,
    input  logic                     write_ready,
    output logic                     write_trigger,
    output logic [DataWidth-1:0]     write_data,
    input  logic                     read_ready,
    output logic                     read_trigger,
    input  logic [DataWidth-1:0]     read_data
`ifdef RAM_TEST_ERRLOG_EN
    ,
    output logic [BlockWidth-1:0]    err_block,
    output logic [IdxWidth-1:0]      err_idx,
    output logic [DataWidth-1:0]     err_exp,
    output logic [DataWidth-1:0]     err_act
`endif
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR_CMD  = 3'd1;
    localparam logic [2:0] ST_WR_WAIT = 3'd2;
    localparam logic [2:0] ST_WR_DATA = 3'd3;
    localparam logic [2:0] ST_RD_CMD  = 3'd4;
    localparam logic [2:0] ST_RD_WAIT = 3'd5;
    localparam logic [2:0] ST_RD_DATA = 3'd6;
    localparam logic [2:0] ST_FINISH  = 3'd7;

    localparam int WdWidth     = `RegWidth(TimeoutCycles);
    localparam int BlkCntWidth = `RegWidth(BlockCount - 1);

    localparam logic [IdxWidth-1:0]      LastIdx = IdxWidth'(BlockSize - 1);
    localparam logic [WdWidth-1:0]       WdLimit = WdWidth'(TimeoutCycles - 1);
    localparam logic [BlkCntWidth-1:0]   LastBlk = BlkCntWidth'(BlockCount - 1);
    localparam logic [ErrCountWidth-1:0] ErrMax  = '1;

    logic [2:0]               state_q,   state_d;
    logic [BlockWidth-1:0]    block_q,   block_d;
    logic [1:0]               mode_q,    mode_d;
    logic [IdxWidth-1:0]      idx_q,     idx_d;
    logic [BlkCntWidth-1:0]   blk_cnt_q, blk_cnt_d;
    logic [WdWidth-1:0]       wd_q,      wd_d;
    logic [ErrCountWidth-1:0] err_q,     err_d;
    logic                     timeout_q, timeout_d;
    logic                     pass_q,    pass_d;

    logic [DataWidth-1:0] pattern_word;

    logic in_wr_data;
    logic in_rd_data;
    logic wr_xfer;
    logic rd_xfer;
    logic xfer;
    logic last_word;
    logic expire;
    logic miscompare;
    logic err_event;
    logic end_block;

    ram_test_pattern #(
        .DataWidth  (DataWidth),
        .BlockWidth (BlockWidth),
        .IdxWidth   (IdxWidth)
    ) u_pattern (
        .mode_i  (mode_q),
        .block_i (block_q),
        .idx_i   (idx_q),
        .word_o  (pattern_word)
    );

    // Transfer, watchdog and compare qualifiers.
    always_comb begin
        in_wr_data = (state_q == ST_WR_DATA);
        in_rd_data = (state_q == ST_RD_DATA);
        wr_xfer    = in_wr_data && write_ready;
        rd_xfer    = in_rd_data && read_ready;
        xfer       = wr_xfer || rd_xfer;
        last_word  = (idx_q == LastIdx);
        // The watchdog counts data-phase cycles without a transfer; the
        // TimeoutCycles-th such cycle abandons the block.
        expire     = (in_wr_data || in_rd_data) && !xfer && (wd_q == WdLimit);
        miscompare = rd_xfer && (read_data != pattern_word);
        // A miscompare and an expiry in the same cycle are one error.
        err_event  = miscompare || expire;
    end

    always_comb begin
        state_d   = state_q;
        block_d   = block_q;
        mode_d    = mode_q;
        idx_d     = idx_q;
        blk_cnt_d = blk_cnt_q;
        wd_d      = '0;
        err_d     = err_q;
        timeout_d = timeout_q;
        pass_d    = pass_q;
        end_block = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    block_d   = start_block;
                    mode_d    = mode;
                    blk_cnt_d = '0;
                    err_d     = '0;
                    timeout_d = 1'b0;
                    pass_d    = 1'b0;
                    state_d   = ST_WR_CMD;
                end
            end
            ST_WR_CMD: begin
                idx_d   = '0;
                state_d = ST_WR_WAIT;
            end
            ST_WR_WAIT: state_d = ST_WR_DATA;
            ST_WR_DATA: begin
                wd_d = xfer ? '0 : wd_q + 1'b1;
                if (expire) begin
                    end_block = 1'b1;
                end else if (wr_xfer) begin
                    idx_d = idx_q + 1'b1;
                    if (last_word) state_d = ST_RD_CMD;
                end
            end
            ST_RD_CMD: begin
                idx_d   = '0;
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: state_d = ST_RD_DATA;
            ST_RD_DATA: begin
                wd_d = xfer ? '0 : wd_q + 1'b1;
                if (expire) begin
                    end_block = 1'b1;
                end else if (rd_xfer) begin
                    idx_d = idx_q + 1'b1;
                    if (last_word) end_block = 1'b1;
                end
            end
            default: state_d = ST_IDLE;  // ST_FINISH
        endcase

        if (err_event && (err_q != ErrMax)) err_d = err_q + 1'b1;
        if (expire) timeout_d = 1'b1;

        // Block address wraps silently modulo 2^BlockWidth.
        if (end_block) begin
            if (blk_cnt_q == LastBlk) begin
                state_d = ST_FINISH;
            end else begin
                state_d   = ST_WR_CMD;
                block_d   = block_q + 1'b1;
                blk_cnt_d = blk_cnt_q + 1'b1;
            end
        end

        if ((StopOnError != 0) && err_event) state_d = ST_FINISH;

        // pass_ok must already be valid in the done cycle, so it is decided
        // from the error count that includes the final transfer.
        if ((state_d == ST_FINISH) && (state_q != ST_FINISH)) pass_d = (err_d == '0);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (!rst_) begin
            state_q   <= ST_IDLE;
            block_q   <= '0;
            mode_q    <= '0;
            idx_q     <= '0;
            blk_cnt_q <= '0;
            wd_q      <= '0;
            err_q     <= '0;
            timeout_q <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            block_q   <= block_d;
            mode_q    <= mode_d;
            idx_q     <= idx_d;
            blk_cnt_q <= blk_cnt_d;
            wd_q      <= wd_d;
            err_q     <= err_d;
            timeout_q <= timeout_d;
            pass_q    <= pass_d;
        end
    end

    // Outputs decode straight from registered state, so a reset leaves no
    // command or trigger pending in the following cycle.
    always_comb begin
        busy          = (state_q != ST_IDLE) && (state_q != ST_FINISH);
        done          = (state_q == ST_FINISH);
        pass_ok       = pass_q;
        err_count     = err_q;
        timeout       = timeout_q;
        cmd_block     = block_q;
        write_trigger = in_wr_data;
        read_trigger  = in_rd_data;
        write_data    = pattern_word;
        case (state_q)
            ST_WR_CMD: cmd = RAMController_Cmd_Write;
            ST_RD_CMD: cmd = RAMController_Cmd_Read;
            default:   cmd = RAMController_Cmd_None;
        endcase
    end

`ifdef RAM_TEST_ERRLOG_EN
    logic                  logged_q,  logged_d;
    logic [BlockWidth-1:0] eblock_q,  eblock_d;
    logic [IdxWidth-1:0]   eidx_q,    eidx_d;
    logic [DataWidth-1:0]  eexp_q,    eexp_d;
    logic [DataWidth-1:0]  eact_q,    eact_d;

    // Only the first miscompare of a run is kept; timeouts never capture.
    always_comb begin
        logged_d = logged_q;
        eblock_d = eblock_q;
        eidx_d   = eidx_q;
        eexp_d   = eexp_q;
        eact_d   = eact_q;
        if ((state_q == ST_IDLE) && start) begin
            logged_d = 1'b0;
            eblock_d = '0;
            eidx_d   = '0;
            eexp_d   = '0;
            eact_d   = '0;
        end else if (miscompare && !logged_q) begin
            logged_d = 1'b1;
            eblock_d = block_q;
            eidx_d   = idx_q;
            eexp_d   = pattern_word;
            eact_d   = read_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            logged_q <= 1'b0;
            eblock_q <= '0;
            eidx_q   <= '0;
            eexp_q   <= '0;
            eact_q   <= '0;
        end else begin
            logged_q <= logged_d;
            eblock_q <= eblock_d;
            eidx_q   <= eidx_d;
            eexp_q   <= eexp_d;
            eact_q   <= eact_d;
        end
    end

    assign err_block = eblock_q;
    assign err_idx   = eidx_q;
    assign err_exp   = eexp_q;
    assign err_act   = eact_q;
`endif

endmodule

// File: tb/tb_ram_test_sequencer.sv
// -----------------------------------------------------------------------------
// tb_ram_test_sequencer
//   Self-checking bench for ram_test_sequencer (BlockSize=32, BlockCount=4).
//   A RAM model stores written words and returns them on reads, optionally
//   flipping one bit or stalling a block's reads. Expected command blocks and
//   write words are queued when a run is launched and popped as the DUT
//   produces them; run results are checked at done.
// -----------------------------------------------------------------------------
module tb_ram_test_sequencer;
    import ram_test_sequencer_pkg::*;

    localparam int DW = 16;
    localparam int BW = 19;
    localparam int BS = 32;
    localparam int BC = 4;
    localparam int IW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_;
    logic          start;
    logic [BW-1:0] start_block;
    logic [1:0]    mode;
    logic          busy;
    logic          done;
    logic          pass_ok;
    logic [15:0]   err_count;
    logic          timeout;
    logic [1:0]    cmd;
    logic [BW-1:0] cmd_block;
    logic          write_ready = 1'b0;
    logic          write_trigger;
    logic [DW-1:0] write_data;
    logic          read_ready = 1'b0;
    logic          read_trigger;
    logic [DW-1:0] read_data = '0;
`ifdef RAM_TEST_ERRLOG_EN
    logic [BW-1:0] err_block;
    logic [IW-1:0] err_idx;
    logic [DW-1:0] err_exp;
    logic [DW-1:0] err_act;
`endif

    ram_test_sequencer #(
        .DataWidth     (DW),
        .BlockWidth    (BW),
        .BlockSize     (BS),
        .BlockCount    (BC),
        .TimeoutCycles (1023),
        .StopOnError   (0)
    ) dut (
        .clk           (clk),
        .rst_          (rst_),
        .start         (start),
        .start_block   (start_block),
        .mode          (mode),
        .busy          (busy),
        .done          (done),
        .pass_ok       (pass_ok),
        .err_count     (err_count),
        .timeout       (timeout),
        .cmd           (cmd),
        .cmd_block     (cmd_block),
        .write_ready   (write_ready),
        .write_trigger (write_trigger),
        .write_data    (write_data),
        .read_ready    (read_ready),
        .read_trigger  (read_trigger),
        .read_data     (read_data)
`ifdef RAM_TEST_ERRLOG_EN
        ,
        .err_block     (err_block),
        .err_idx       (err_idx),
        .err_exp       (err_exp),
        .err_act       (err_act)
`endif
    );

    int checks = 0;
    int errors = 0;

    logic [31:0]   blk_q[$];
    logic [31:0]   wr_q[$];
    logic [DW-1:0] mem[int];
    logic [BW-1:0] cur_block = '0;
    int            wr_idx = 0;
    int            rd_idx = 0;
    int            rd_cmds = 0;

    bit            flip_en = 0;
    logic [BW-1:0] flip_block = '0;
    int            flip_idx = 0;
    bit            stall_en = 0;
    logic [BW-1:0] stall_block = '0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input logic [1:0] m, input logic [BW-1:0] b, input int i);
        logic [DW-1:0] x;
        x = b[DW-1:0] ^ DW'(i);
        case (m)
            2'd0:    return x;
            2'd1:    return DW'(i);
            2'd2:    return ~x;
            default: return DW'(1) << (i % DW);
        endcase
    endfunction

    function automatic int key(input logic [BW-1:0] b, input int i);
        return int'(b) * 64 + i;
    endfunction

    // RAM model + scoreboard consumer, evaluated on the falling edge.
    task automatic monitor_loop();
        logic [31:0] exp;
        forever begin
            @(negedge clk);
            if (cmd == RAMController_Cmd_Write) begin
                exp = (blk_q.size() != 0) ? blk_q.pop_front() : 32'hFFFF_FFFF;
                check("wr_cmd_block", 32'(cmd_block), exp);
                cur_block = exp[BW-1:0];
                wr_idx = 0;
            end
            if (cmd == RAMController_Cmd_Read) begin
                check("rd_cmd_block", 32'(cmd_block), 32'(cur_block));
                rd_idx = 0;
                rd_cmds++;
            end
            write_ready = ($urandom_range(0, 3) != 0);
            read_ready  = (stall_en && cur_block == stall_block) ? 1'b0 : ($urandom_range(0, 3) != 0);
            read_data   = mem.exists(key(cur_block, rd_idx)) ? mem[key(cur_block, rd_idx)] : '0;
            if (flip_en && cur_block == flip_block && rd_idx == flip_idx) read_data[0] = ~read_data[0];
            if (write_trigger && write_ready) begin
                exp = (wr_q.size() != 0) ? wr_q.pop_front() : 32'hFFFF_FFFF;
                check("write_data", 32'(write_data), exp);
                mem[key(cur_block, wr_idx)] = write_data;
                wr_idx++;
            end
            if (read_trigger && read_ready) rd_idx++;
        end
    endtask

    task automatic push_run(input logic [BW-1:0] sb, input logic [1:0] m);
        for (int b = 0; b < BC; b++) begin
            logic [BW-1:0] blk;
            blk = sb + BW'(b);
            blk_q.push_back(32'(blk));
            for (int i = 0; i < BS; i++) wr_q.push_back(32'(pat(m, blk, i)));
        end
    endtask

    task automatic run_test(input logic [BW-1:0] sb, input logic [1:0] m, input int exp_err,
                            input logic exp_to, input bit poke_busy);
        int  rd_before;
        bit  seen;
        push_run(sb, m);
        rd_before = rd_cmds;
        start_block = sb;
        mode = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_to_write", 32'(cmd), 32'(RAMController_Cmd_Write));
        check("busy_after_start", 32'(busy), 32'd1);
        if (poke_busy) begin
            repeat (5) @(negedge clk);
            start_block = 19'h00123;
            mode = 2'd1;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("busy_start_ignored", 32'(busy), 32'd1);
        end
        seen = 0;
        for (int c = 0; c < 20000 && !seen; c++) begin
            @(negedge clk);
            seen = done;
        end
        check("done_seen", 32'(done), 32'd1);
        check("pass_ok", 32'(pass_ok), 32'(exp_err == 0));
        check("err_count", 32'(err_count), 32'(exp_err));
        check("timeout", 32'(timeout), 32'(exp_to));
        check("busy_at_done", 32'(busy), 32'd0);
        check("writes_left", 32'(wr_q.size()), 32'd0);
        check("blocks_left", 32'(blk_q.size()), 32'd0);
        check("read_blocks", 32'(rd_cmds - rd_before), 32'(BC));
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd0);
        check("pass_hold", 32'(pass_ok), 32'(exp_err == 0));
    endtask

    initial begin
        bit seen;
        rst_ = 1'b0;
        start = 1'b0;
        start_block = '0;
        mode = '0;
        fork
            monitor_loop();
        join_none

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass_ok), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_err", 32'(err_count), 32'd0);
        check("rst_cmd", 32'(cmd), 32'(RAMController_Cmd_None));
        check("rst_wtrig", 32'(write_trigger), 32'd0);
        check("rst_rtrig", 32'(read_trigger), 32'd0);
        check("rst_cmd_block", 32'(cmd_block), 32'd0);
        rst_ = 1'b1;
        @(negedge clk);

        // 1: clean run, mode 0.
        run_test(19'h00010, 2'd0, 0, 1'b0, 0);

        // 2: one flipped bit in block 0x11 word 5.
        flip_en = 1;
        flip_block = 19'h00011;
        flip_idx = 5;
        run_test(19'h00010, 2'd0, 1, 1'b0, 0);
        flip_en = 0;
`ifdef RAM_TEST_ERRLOG_EN
        check("log_block", 32'(err_block), 32'h11);
        check("log_idx", 32'(err_idx), 32'd5);
        check("log_exp", 32'(err_exp), 32'(pat(2'd0, 19'h00011, 5)));
        check("log_act", 32'(err_act), 32'(pat(2'd0, 19'h00011, 5) ^ 16'h0001));
`endif

        // 3: reads of the first block stalled past the watchdog.
        stall_en = 1;
        stall_block = 19'h00040;
        run_test(19'h00040, 2'd1, 1, 1'b1, 0);
        stall_en = 0;

        // 4: block address wrap, start pulsed while busy.
        run_test(19'h7FFFF, 2'd2, 0, 1'b0, 1);

        // 5: reset in the middle of a write burst, then a clean run.
        push_run(19'h00030, 2'd0);
        start_block = 19'h00030;
        mode = 2'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            seen = write_trigger;
        end
        check("mid_wr_active", 32'(write_trigger), 32'd1);
        rst_ = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_wtrig", 32'(write_trigger), 32'd0);
        check("mid_rst_cmd", 32'(cmd), 32'(RAMController_Cmd_None));
        check("mid_rst_err", 32'(err_count), 32'd0);
        check("mid_rst_cmd_block", 32'(cmd_block), 32'd0);
        rst_ = 1'b1;
        @(negedge clk);
        blk_q.delete();
        wr_q.delete();
        run_test(19'h00030, 2'd0, 0, 1'b0, 0);

        // 6: walking one wraps at DataWidth: word 17 is 16'h0002.
        run_test(19'h00020, 2'd3, 0, 1'b0, 0);
        check("walk_word17_blk0", 32'(mem[key(19'h00020, 17)]), 32'h0002);
        check("walk_word17_blk3", 32'(mem[key(19'h00023, 17)]), 32'h0002);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
